fpdiv_sched: RTL and testbench

Round-robin scheduler that shares one fpdiv instance among NREQ requesters. It accepts one divide request at a time and latches the operands and rounding mode. It drives the divider's start/operand interface, waits for completion, and returns the result, flags and denorm bit tagged with the requester id. It sits between the FP issue logic and the single fpdiv datapath.

---
 rtl/fpdiv_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_fpdiv_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpdiv_sched.sv
// fpdiv_sched: round-robin scheduler sharing one fpdiv datapath among NREQ requesters.
// Latency: fixed mode answers START_CYC+LAT+1 cycles after acceptance; done mode one cycle after div_done (or TMO).
// Backpressure: req_ready is a one-hot grant raised only in IDLE; requesters stall while an operation is in flight.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester handshake (ready is the one-hot grant)
//   req_op1/op2/rm/op_type     per-requester operands, packed slice i per requester
//   cfg_P/OvEn/UnEn            static controls, latched with each accepted request
//   div_*                      start/operand interface to the shared fpdiv, result/flags/denorm back
//   rsp_*                      one-cycle response strobe plus held id/result/flags/denorm/timeout
//   busy                       high whenever an operation is in progress
module fpdiv_sched #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int START_CYC = 2,
  parameter int USE_DONE  = 1,
  parameter int LAT       = 10,
  parameter int TMO       = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [64*NREQ-1:0]   req_op1,
  input  logic [64*NREQ-1:0]   req_op2,
  input  logic [3*NREQ-1:0]    req_rm,
  input  logic [NREQ-1:0]      req_op_type,
  input  logic                 cfg_P,
  input  logic                 cfg_OvEn,
  input  logic                 cfg_UnEn,
  output logic [63:0]          div_op1,
  output logic [63:0]          div_op2,
  output logic [2:0]           div_rm,
  output logic                 div_op_type,
  output logic                 div_P,
  output logic                 div_OvEn,
  output logic                 div_UnEn,
  output logic                 div_start,
  input  logic                 div_done,
  input  logic [63:0]          div_result,
  input  logic [4:0]           div_flags,
  input  logic                 div_denorm,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_result,
  output logic [4:0]           rsp_flags,
  output logic                 rsp_denorm,
  output logic                 rsp_timeout,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // One counter serves both ISSUE and WAIT; size it for the longest phase.
  localparam int CMAX_LT = (TMO > LAT) ? TMO : LAT;
  localparam int CMAX    = (CMAX_LT > START_CYC) ? CMAX_LT : START_CYC;
  localparam int CW      = $clog2(CMAX + 1);

  localparam logic [CW-1:0]  C_ISSUE_END = CW'(START_CYC - 1);
  localparam logic [CW-1:0]  C_LAT_END   = CW'(LAT - 1);
  localparam logic [CW-1:0]  C_TMO_END   = CW'(TMO - 1);
  localparam logic [IDW-1:0] C_LAST_ID   = IDW'(NREQ - 1);

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_id;

  logic [63:0]    r_div_op1;
  logic [63:0]    r_div_op2;
  logic [2:0]     r_div_rm;
  logic           r_div_op_type;
  logic           r_div_p;
  logic           r_div_oven;
  logic           r_div_unen;

  logic [IDW-1:0] r_rsp_id;
  logic [63:0]    r_rsp_result;
  logic [4:0]     r_rsp_flags;
  logic           r_rsp_denorm;
  logic           r_rsp_timeout;

  logic           w_gnt_vld;
  logic [IDW-1:0] w_gnt_id;
  logic [IDW-1:0] w_rr_next;
  logic [63:0]    w_sel_op1;
  logic [63:0]    w_sel_op2;
  logic [2:0]     w_sel_rm;
  logic           w_sel_op_type;
  logic           w_tmo_hit;
  logic           w_capture;
  logic           w_timeout;

  // Search from r_rr_ptr upward with wrap. Walking offsets high-to-low and
  // overwriting leaves the lowest matching offset as the winner.
  always_comb begin : grant_search
    int idx;
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = IDW'(idx);
      end
    end
  end

  assign w_rr_next = (w_gnt_id == C_LAST_ID) ? '0 : w_gnt_id + 1'b1;

  always_comb begin
    w_sel_op1     = '0;
    w_sel_op2     = '0;
    w_sel_rm      = '0;
    w_sel_op_type = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_id == IDW'(i)) begin
        w_sel_op1     = req_op1[i*64 +: 64];
        w_sel_op2     = req_op2[i*64 +: 64];
        w_sel_rm      = req_rm[i*3 +: 3];
        w_sel_op_type = req_op_type[i];
      end
    end
  end

  // The state already reads IDLE while reset is held, so the grant is also
  // qualified by reset to keep req_ready low for the whole reset period.
  always_comb begin
    req_ready = '0;
    if (reset && (r_state == S_IDLE) && w_gnt_vld) begin
      req_ready[w_gnt_id] = 1'b1;
    end
  end

  // Done mode: div_done wins over a timeout landing on the same cycle.
  assign w_tmo_hit = (r_cnt == C_TMO_END);
  assign w_capture = (USE_DONE != 0) ? (div_done | w_tmo_hit) : (r_cnt == C_LAT_END);
  assign w_timeout = (USE_DONE != 0) & ~div_done & w_tmo_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
      r_id     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_id     <= w_gnt_id;
            r_rr_ptr <= w_rr_next;
            r_cnt    <= '0;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_cnt == C_ISSUE_END) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (w_capture) begin
            r_cnt   <= '0;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Divider operands change only on acceptance, so they stay stable
  // from ISSUE through RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_op1     <= '0;
      r_div_op2     <= '0;
      r_div_rm      <= '0;
      r_div_op_type <= 1'b0;
      r_div_p       <= 1'b0;
      r_div_oven    <= 1'b0;
      r_div_unen    <= 1'b0;
    end else if ((r_state == S_IDLE) && w_gnt_vld) begin
      r_div_op1     <= w_sel_op1;
      r_div_op2     <= w_sel_op2;
      r_div_rm      <= w_sel_rm;
      r_div_op_type <= w_sel_op_type;
      r_div_p       <= cfg_P;
      r_div_oven    <= cfg_OvEn;
      r_div_unen    <= cfg_UnEn;
    end
  end

  // Response fields hold between captures; only rsp_valid pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_id      <= '0;
      r_rsp_result  <= '0;
      r_rsp_flags   <= '0;
      r_rsp_denorm  <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else if ((r_state == S_WAIT) && w_capture) begin
      r_rsp_id      <= r_id;
      r_rsp_result  <= div_result;
      r_rsp_flags   <= div_flags;
      r_rsp_denorm  <= div_denorm;
      r_rsp_timeout <= w_timeout;
    end
  end

  assign div_op1     = r_div_op1;
  assign div_op2     = r_div_op2;
  assign div_rm      = r_div_rm;
  assign div_op_type = r_div_op_type;
  assign div_P       = r_div_p;
  assign div_OvEn    = r_div_oven;
  assign div_UnEn    = r_div_unen;
  assign div_start   = (r_state == S_ISSUE);

  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_id      = r_rsp_id;
  assign rsp_result  = r_rsp_result;
  assign rsp_flags   = r_rsp_flags;
  assign rsp_denorm  = r_rsp_denorm;
  assign rsp_timeout = r_rsp_timeout;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpdiv_sched.sv
// tb_fpdiv_sched: checks fpdiv_sched in fixed-latency and done-driven modes.
// Latency: n/a (bench).
// Backpressure: requests are held until granted, then kept asserted to probe grant suppression while busy.
module tb_fpdiv_sched;
  localparam int NREQ      = 4;
  localparam int IDW       = 2;
  localparam int START_CYC = 2;
  localparam int LAT       = 10;
  localparam int TMO       = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [64*NREQ-1:0] op1_bus, op2_bus;
  logic [3*NREQ-1:0]  rm_bus;
  logic [NREQ-1:0]    ot_bus;
  logic               cfg_p, cfg_ov, cfg_un;
  logic [4:0]         stub_flags;
  logic               stub_denorm;

  // fixed-latency instance
  logic [NREQ-1:0] f_req_valid, f_req_ready;
  logic [63:0]     f_div_op1, f_div_op2, f_div_result, f_rsp_result;
  logic [2:0]      f_div_rm;
  logic            f_div_op_type, f_div_p, f_div_ov, f_div_un, f_div_start;
  logic            f_rsp_valid, f_rsp_denorm, f_rsp_timeout, f_busy;
  logic [4:0]      f_rsp_flags;
  logic [IDW-1:0]  f_rsp_id;

  // done-driven instance
  logic [NREQ-1:0] d_req_valid, d_req_ready;
  logic [63:0]     d_div_op1, d_div_op2, d_div_result, d_rsp_result;
  logic [2:0]      d_div_rm;
  logic            d_div_op_type, d_div_p, d_div_ov, d_div_un, d_div_start, d_div_done;
  logic            d_rsp_valid, d_rsp_denorm, d_rsp_timeout, d_busy;
  logic [4:0]      d_rsp_flags;
  logic [IDW-1:0]  d_rsp_id;

  // Divider stand-in: a true IEEE double divide of whatever the DUT presents.
  assign f_div_result = $realtobits($bitstoreal(f_div_op1) / $bitstoreal(f_div_op2));
  assign d_div_result = $realtobits($bitstoreal(d_div_op1) / $bitstoreal(d_div_op2));

  fpdiv_sched #(.NREQ(NREQ), .IDW(IDW), .START_CYC(START_CYC), .USE_DONE(0), .LAT(LAT), .TMO(TMO)) u_fix (
    .clk(clk), .reset(rst_n),
    .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_op1(op1_bus), .req_op2(op2_bus), .req_rm(rm_bus), .req_op_type(ot_bus),
    .cfg_P(cfg_p), .cfg_OvEn(cfg_ov), .cfg_UnEn(cfg_un),
    .div_op1(f_div_op1), .div_op2(f_div_op2), .div_rm(f_div_rm), .div_op_type(f_div_op_type),
    .div_P(f_div_p), .div_OvEn(f_div_ov), .div_UnEn(f_div_un), .div_start(f_div_start),
    .div_done(1'b0), .div_result(f_div_result), .div_flags(stub_flags), .div_denorm(stub_denorm),
    .rsp_valid(f_rsp_valid), .rsp_id(f_rsp_id), .rsp_result(f_rsp_result), .rsp_flags(f_rsp_flags),
    .rsp_denorm(f_rsp_denorm), .rsp_timeout(f_rsp_timeout), .busy(f_busy)
  );

  fpdiv_sched #(.NREQ(NREQ), .IDW(IDW), .START_CYC(START_CYC), .USE_DONE(1), .LAT(LAT), .TMO(TMO)) u_done (
    .clk(clk), .reset(rst_n),
    .req_valid(d_req_valid), .req_ready(d_req_ready),
    .req_op1(op1_bus), .req_op2(op2_bus), .req_rm(rm_bus), .req_op_type(ot_bus),
    .cfg_P(cfg_p), .cfg_OvEn(cfg_ov), .cfg_UnEn(cfg_un),
    .div_op1(d_div_op1), .div_op2(d_div_op2), .div_rm(d_div_rm), .div_op_type(d_div_op_type),
    .div_P(d_div_p), .div_OvEn(d_div_ov), .div_UnEn(d_div_un), .div_start(d_div_start),
    .div_done(d_div_done), .div_result(d_div_result), .div_flags(stub_flags), .div_denorm(stub_denorm),
    .rsp_valid(d_rsp_valid), .rsp_id(d_rsp_id), .rsp_result(d_rsp_result), .rsp_flags(d_rsp_flags),
    .rsp_denorm(d_rsp_denorm), .rsp_timeout(d_rsp_timeout), .busy(d_busy)
  );

  // Reference model state: round-robin pointers and per-requester operands.
  int          f_rr, d_rr;
  logic [63:0] op_a [NREQ];
  logic [63:0] op_b [NREQ];
  logic [2:0]  op_rm [NREQ];
  logic        op_ot [NREQ];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
    for (int o = 0; o < NREQ; o++) begin
      if (m[(p + o) % NREQ]) return (p + o) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [63:0] rand_op();
    real r;
    r = real'($urandom_range(1, 1048576)) / 1024.0;
    if ($urandom_range(0, 1) == 1) r = -r;
    return $realtobits(r);
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      op1_bus[i*64 +: 64] = op_a[i];
      op2_bus[i*64 +: 64] = op_b[i];
      rm_bus[i*3 +: 3]    = op_rm[i];
      ot_bus[i]           = op_ot[i];
    end
  endtask

  task automatic set_ops_dir(input logic [63:0] a, input logic [63:0] b, input logic [2:0] rm);
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = a; op_b[i] = b; op_rm[i] = rm; op_ot[i] = 1'b0;
    end
    cfg_p = 1'b0; cfg_ov = 1'b0; cfg_un = 1'b0;
    stub_flags = 5'd0; stub_denorm = 1'b0;
  endtask

  task automatic set_ops_rand();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i]  = rand_op();
      op_b[i]  = rand_op();
      op_rm[i] = 3'($urandom_range(0, 7));
      op_ot[i] = 1'($urandom_range(0, 1));
    end
    cfg_p = 1'($urandom_range(0, 1)); cfg_ov = 1'($urandom_range(0, 1)); cfg_un = 1'($urandom_range(0, 1));
    stub_flags = 5'($urandom_range(0, 31)); stub_denorm = 1'($urandom_range(0, 1));
  endtask

  // Fixed mode: called at a negedge with the DUT idle; returns granted id.
  task automatic fix_txn(input logic [NREQ-1:0] mask, output int gid);
    int nstart, first_start, rsp_cyc;
    bit got;
    logic [63:0] exp_res;
    drive_reqs();
    f_req_valid = mask;
    #1;
    gid = rr_pick(mask, f_rr);
    chk("f_grant", 64'(f_req_ready), 64'(1) << gid);
    f_rr = (gid + 1) % NREQ;
    exp_res = $realtobits($bitstoreal(op_a[gid]) / $bitstoreal(op_b[gid]));
    nstart = 0; first_start = 0; rsp_cyc = 0; got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      chk("f_no_grant_busy", 64'(f_req_ready), 64'd0);
      if (f_div_start) begin
        nstart++;
        if (first_start == 0) first_start = c;
        chk("f_op1", f_div_op1, op_a[gid]);
        chk("f_op2", f_div_op2, op_b[gid]);
        chk("f_ctl", 64'({f_div_rm, f_div_op_type, f_div_p, f_div_ov, f_div_un}),
            64'({op_rm[gid], op_ot[gid], cfg_p, cfg_ov, cfg_un}));
      end
      if (f_rsp_valid) begin
        got = 1'b1;
        rsp_cyc = c;
        chk("f_rsp_id", 64'(f_rsp_id), 64'(gid));
        chk("f_rsp_result", f_rsp_result, exp_res);
        chk("f_rsp_flags", 64'(f_rsp_flags), 64'(stub_flags));
        chk("f_rsp_denorm", 64'(f_rsp_denorm), 64'(stub_denorm));
        chk("f_rsp_timeout", 64'(f_rsp_timeout), 64'd0);
        chk("f_op1_stable", f_div_op1, op_a[gid]);
        chk("f_busy_resp", 64'(f_busy), 64'd1);
      end
    end
    f_req_valid = '0;
    chk("f_rsp_seen", 64'(got), 64'd1);
    chk("f_latency", 64'(rsp_cyc), 64'(START_CYC + LAT + 1));
    chk("f_start_cycles", 64'(nstart), 64'(START_CYC));
    chk("f_start_first", 64'(first_start), 64'd1);
    @(negedge clk);
    chk("f_rsp_pulse", 64'(f_rsp_valid), 64'd0);
    chk("f_rsp_hold", f_rsp_result, exp_res);
    chk("f_idle", 64'(f_busy), 64'd0);
  endtask

  // Done mode: k = WAIT cycle index where div_done is raised (<0: never).
  task automatic done_txn(input logic [NREQ-1:0] mask, input int k, input bit pulse, output int gid);
    int nstart, rsp_cyc, exp_cyc;
    bit got, exp_tmo;
    logic [63:0] exp_res;
    drive_reqs();
    d_req_valid = mask;
    #1;
    gid = rr_pick(mask, d_rr);
    chk("d_grant", 64'(d_req_ready), 64'(1) << gid);
    d_rr = (gid + 1) % NREQ;
    exp_res = $realtobits($bitstoreal(op_a[gid]) / $bitstoreal(op_b[gid]));
    exp_tmo = !(k >= 0 && k < TMO);
    exp_cyc = exp_tmo ? (START_CYC + 1 + TMO) : (START_CYC + 2 + k);
    nstart = 0; rsp_cyc = 0; got = 1'b0;
    for (int c = 1; c <= TMO + 20 && !got; c++) begin
      @(negedge clk);
      chk("d_no_grant_busy", 64'(d_req_ready), 64'd0);
      if (d_div_start) nstart++;
      if (d_rsp_valid) begin
        got = 1'b1;
        rsp_cyc = c;
        chk("d_rsp_id", 64'(d_rsp_id), 64'(gid));
        chk("d_rsp_result", d_rsp_result, exp_res);
        chk("d_rsp_flags", 64'(d_rsp_flags), 64'(stub_flags));
        chk("d_rsp_denorm", 64'(d_rsp_denorm), 64'(stub_denorm));
        chk("d_rsp_timeout", 64'(d_rsp_timeout), 64'(exp_tmo));
        chk("d_ctl_stable", 64'({d_div_rm, d_div_op_type, d_div_p, d_div_ov, d_div_un}),
            64'({op_rm[gid], op_ot[gid], cfg_p, cfg_ov, cfg_un}));
      end
      d_div_done = (pulse && c == 1) || (k >= 0 && c == START_CYC + 1 + k);
    end
    d_div_done  = 1'b0;
    d_req_valid = '0;
    chk("d_rsp_seen", 64'(got), 64'd1);
    chk("d_latency", 64'(rsp_cyc), 64'(exp_cyc));
    chk("d_start_cycles", 64'(nstart), 64'(START_CYC));
    @(negedge clk);
    chk("d_rsp_pulse", 64'(d_rsp_valid), 64'd0);
    chk("d_idle", 64'(d_busy), 64'd0);
  endtask

  initial begin
    int g;
    rst_n = 1'b0;
    d_div_done = 1'b0;
    set_ops_dir(64'h3FF0000000000000, 64'h4000000000000000, 3'b011);
    drive_reqs();
    f_req_valid = '1;
    d_req_valid = '1;
    f_rr = 0; d_rr = 0;
    #3;
    chk("rst_f_ready", 64'(f_req_ready), 64'd0);
    chk("rst_d_ready", 64'(d_req_ready), 64'd0);
    chk("rst_f_start", 64'(f_div_start), 64'd0);
    chk("rst_f_busy", 64'(f_busy), 64'd0);
    chk("rst_f_rsp", 64'({f_rsp_valid, f_rsp_id, f_rsp_flags, f_rsp_denorm, f_rsp_timeout}), 64'd0);
    chk("rst_f_result", f_rsp_result, 64'd0);
    chk("rst_f_op1", f_div_op1, 64'd0);
    chk("rst_d_busy", 64'(d_busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    f_req_valid = '0;
    d_req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);

    // single request, fixed mode: 1.0 / 2.0
    fix_txn(4'b0001, g);
    chk("t1_result", f_rsp_result, 64'h3FE0000000000000);
    chk("t1_flags", 64'(f_rsp_flags), 64'd0);

    // bring the pointer back to 0, then all four contend: 0,1,2,3,0
    fix_txn(4'b1000, g);
    set_ops_dir(64'h4018000000000000, 64'h4008000000000000, 3'b000);
    for (int n = 0; n < 5; n++) begin
      fix_txn(4'b1111, g);
      chk("rr_order", 64'(g), 64'(n % NREQ));
      chk("rr_result", f_rsp_result, 64'h4000000000000000);
    end

    // pointer wrap: leave pointer at 2, then 3 and 1 contend
    fix_txn(4'b0010, g);
    fix_txn(4'b1010, g);
    chk("wrap_first", 64'(g), 64'd3);
    fix_txn(4'b1010, g);
    chk("wrap_second", 64'(g), 64'd1);
    fix_txn(4'b1111, g);
    chk("wrap_ptr_after", 64'(g), 64'd2);

    for (int n = 0; n < 20; n++) begin
      set_ops_rand();
      fix_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), g);
    end

    // done mode: done 5 cycles into WAIT, stray done pulse during ISSUE
    set_ops_dir(64'h3FF0000000000000, 64'h4000000000000000, 3'b011);
    done_txn(4'b0001, 5, 1'b1, g);
    chk("done_result", d_rsp_result, 64'h3FE0000000000000);

    // timeout: div_done never arrives
    set_ops_rand();
    done_txn(4'b0110, -1, 1'b0, g);
    chk("tmo_flag_held", 64'(d_rsp_timeout), 64'd1);

    for (int n = 0; n < 10; n++) begin
      set_ops_rand();
      done_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)), g);
    end

    // asynchronous reset in the middle of WAIT
    set_ops_rand();
    drive_reqs();
    d_req_valid = 4'b0100;
    repeat (6) @(negedge clk);
    chk("rst_mid_busy", 64'(d_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_ready", 64'(d_req_ready), 64'd0);
    chk("rstm_start", 64'(d_div_start), 64'd0);
    chk("rstm_busy", 64'(d_busy), 64'd0);
    chk("rstm_rsp", 64'({d_rsp_valid, d_rsp_id, d_rsp_flags, d_rsp_denorm, d_rsp_timeout}), 64'd0);
    chk("rstm_result", d_rsp_result, 64'd0);
    chk("rstm_ops", d_div_op1 | d_div_op2, 64'd0);
    chk("rstm_ctl", 64'({d_div_rm, d_div_op_type, d_div_p, d_div_ov, d_div_un}), 64'd0);
    d_req_valid = '0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rstm_no_rsp", 64'(d_rsp_valid), 64'd0);
    end
    rst_n = 1'b1;
    f_rr = 0;
    d_rr = 0;
    @(negedge clk);
    chk("rstm_no_rsp_after", 64'(d_rsp_valid), 64'd0);
    set_ops_rand();
    done_txn(4'b1111, 2, 1'b0, g);
    chk("rstm_fresh_grant", 64'(g), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
